// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave: Wishbone slave with a byte-writable single-port word RAM.
// Answers each strobe with ack (hit), err (miss/misaligned) or, when built
// with WB_RAM_RETRY_EN, rty while busy_i is high. Responses are decoded from
// the registered FSM state, so there is no combinational stb->ack path.
module wishbone_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TAGSIZE     = 2,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [TAGSIZE-1:0] wb_tgd_i,
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  input  logic [31:0]        wb_adr_i,
  input  logic [TAGSIZE-1:0] wb_tga_i,
  input  logic               wb_cyc_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_lock_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
`ifdef WB_RAM_RETRY_EN
  ,
  input  logic               busy_i
`endif
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [2:0]  LP_WAIT = 3'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_ERR,
    S_RTY
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdat;
  logic [TAGSIZE-1:0]    r_tga;
  logic [2:0]            r_cnt;
  logic [31:0]           r_mem [DEPTH];

  logic w_req;
  logic w_hit;
  logic w_busy;
  logic w_capture;
  logic w_unused;

  assign w_unused = ^{wb_tgd_i, wb_tgc_i, wb_lock_i};

`ifdef WB_RAM_RETRY_EN
  assign w_busy = busy_i;
`else
  assign w_busy = 1'b0;
`endif

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_hit     = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) &&
                     (wb_adr_i[1:0] == 2'b00);
  assign w_capture = (r_state == S_IDLE) && w_req && w_hit && !w_busy;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; err wins over rty so a bad address never retries
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (!w_hit)                w_next = S_ERR;
          else if (w_busy)           w_next = S_RTY;
          else if (WAIT_CYCLES == 0) w_next = S_RESP;
          else                       w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i)          w_next = S_IDLE;
        else if (r_cnt == 3'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      S_RTY:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_idx  <= '0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_wdat <= '0;
      r_tga  <= '0;
      r_cnt  <= '0;
    end else if (w_capture) begin
      r_idx  <= wb_adr_i[ADDR_WIDTH+1:2];
      r_we   <= wb_we_i;
      r_sel  <= wb_sel_i;
      r_wdat <= wb_dat_i;
      r_tga  <= wb_tga_i;
      r_cnt  <= LP_WAIT;
    end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
      r_cnt  <= r_cnt - 3'd1;
    end
  end

  // Byte-lane RAM write at the end of the RESP cycle (reset drops it)
  always_ff @(posedge clk_i) begin
    if ((r_state == S_RESP) && r_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_sel[i]) r_mem[r_idx][8*i +: 8] <= r_wdat[8*i +: 8];
      end
    end
  end

  // State-decoded responses
  always_comb begin
    wb_ack_o = (r_state == S_RESP);
    wb_err_o = (r_state == S_ERR);
`ifdef WB_RAM_RETRY_EN
    wb_rty_o = (r_state == S_RTY);
`else
    wb_rty_o = 1'b0;
`endif
    wb_tgd_o = (r_state == S_RESP) ? r_tga : '0;
    wb_dat_o = ((r_state == S_RESP) && !r_we) ? r_mem[r_idx] : '0;
  end

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave: three instances (WAIT_CYCLES 1, 0, 3) share one
// master bus; each test observes only the instance it targets.
module tb_wishbone_ram_slave;

  logic        clk;
  logic        rstn;
  logic        cyc, stb, we, busy;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [1:0]  tga;

  logic        ack [3];
  logic        err [3];
  logic        rty [3];
  logic [31:0] dat [3];
  logic [1:0]  tgd [3];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int viol     = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    wishbone_ram_slave #(
      .ADDR_WIDTH (10),
      .TAGSIZE    (2),
      .WAIT_CYCLES(W),
      .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .wb_dat_i (wdat),
      .wb_tgd_i (2'b00),
      .wb_dat_o (dat[g]),
      .wb_tgd_o (tgd[g]),
      .wb_adr_i (adr),
      .wb_tga_i (tga),
      .wb_cyc_i (cyc),
      .wb_tgc_i (2'b00),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_lock_i(1'b0),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g]),
      .wb_rty_o (rty[g])
`ifdef WB_RAM_RETRY_EN
      ,
      .busy_i   (busy)
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // One transaction on instance d; kind 1=ack 2=err 3=rty 0=timeout
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input logic [1:0] tg,
                      output int kind, output int lat, output logic [31:0] rd,
                      output logic [1:0] rt);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = wd; tga = tg;
    kind = 0; lat = 0; rd = '0; rt = '0;
    for (int n = 1; n <= 12; n++) begin
      if (kind == 0) begin
        @(posedge clk); #1;
        if (ack[d])      begin kind = 1; lat = n; rd = dat[d]; rt = tgd[d]; end
        else if (err[d]) begin kind = 2; lat = n; rd = dat[d]; rt = tgd[d]; end
        else if (rty[d]) begin kind = 3; lat = n; rd = dat[d]; rt = tgd[d]; end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Protocol monitor: exclusivity, single-cycle pulses, rty tied low by default
  logic [2:0] pa = '0, pe = '0, pr = '0;
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if ((int'(ack[d]) + int'(err[d]) + int'(rty[d])) > 1) viol++;
      if ((ack[d] && pa[d]) || (err[d] && pe[d]) || (rty[d] && pr[d])) viol++;
`ifndef WB_RAM_RETRY_EN
      if (rty[d]) viol++;
`endif
      pa[d] = ack[d]; pe[d] = err[d]; pr[d] = rty[d];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [1:0]  tg;
    int          kind;
    int          lat;
    logic [31:0] rd;
    logic [1:0]  rt;
  } vec_t;

  vec_t vt [13];

  initial begin
    int          kind, lat, beat, nack;
    logic [31:0] rd;
    logic [1:0]  rt;

    // Vectors on instance 0 (WAIT_CYCLES=1): ack at 2, err at 1
    vt[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 2'd1, 1, 2, 32'h0,           2'd1};
    vt[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 2'd1, 1, 2, 32'h0,           2'd1};
    vt[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         2'd2, 1, 2, 32'hDEAD_BEEF,   2'd2};
    vt[3]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 2'd3, 1, 2, 32'h0,           2'd3};
    vt[4]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         2'd0, 1, 2, 32'hDEAD_BEAA,   2'd0};
    vt[5]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 2'd1, 1, 2, 32'h0,           2'd1};
    vt[6]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         2'd2, 1, 2, 32'hDEAD_BEAA,   2'd2};
    vt[7]  = '{1'b1, 32'h0000_0010, 4'h4, 32'h0055_0000, 2'd0, 1, 2, 32'h0,           2'd0};
    vt[8]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         2'd1, 1, 2, 32'hDE55_BEAA,   2'd1};
    vt[9]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h1111_1111, 2'd3, 2, 1, 32'h0,           2'd0};
    vt[10] = '{1'b0, 32'h0000_0002, 4'hF, 32'h0,         2'd3, 2, 1, 32'h0,           2'd0};
    vt[11] = '{1'b1, 32'h0000_0002, 4'hF, 32'hFFFF_FFFF, 2'd2, 2, 1, 32'h0,           2'd0};
    vt[12] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         2'd1, 1, 2, 32'hCAFE_F00D,   2'd1};

    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
    adr = '0; wdat = '0; sel = '0; tga = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_resp%0d", d), {29'h0, ack[d], err[d], rty[d]}, 32'h0);
      chk($sformatf("rst_dat%0d", d), dat[d], 32'h0);
      chk($sformatf("rst_tgd%0d", d), {30'h0, tgd[d]}, 32'h0);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      xfer(0, vt[i].we, vt[i].adr, vt[i].sel, vt[i].wd, vt[i].tg, kind, lat, rd, rt);
      chk($sformatf("v%0d_kind", i), 32'(kind), 32'(vt[i].kind));
      chk($sformatf("v%0d_lat", i),  32'(lat),  32'(vt[i].lat));
      chk($sformatf("v%0d_dat", i),  rd,        vt[i].rd);
      chk($sformatf("v%0d_tgd", i),  {30'h0, rt}, {30'h0, vt[i].rt});
    end

    // Reset asserted during a read RESP: outputs drop at once
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF; tga = 2'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstresp_ack_before", {31'h0, ack[0]}, 32'h1);
    chk("rstresp_dat_before", dat[0], 32'hDE55_BEAA);
    rstn = 1'b0;
    #1;
    chk("rstresp_ack", {31'h0, ack[0]}, 32'h0);
    chk("rstresp_dat", dat[0], 32'h0);
    chk("rstresp_tgd", {30'h0, tgd[0]}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 2'd2, kind, lat, rd, rt);
    chk("after_rst_kind", 32'(kind), 32'd1);
    chk("after_rst_lat", 32'(lat), 32'd2);
    chk("after_rst_dat", rd, 32'hDE55_BEAA);

    // Burst of 3 reads on instance 1 (WAIT_CYCLES=0)
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b1, 32'(i * 4), 4'hF, 32'(i + 1), 2'd0, kind, lat, rd, rt);
      chk($sformatf("preload%0d", i), 32'(kind), 32'd1);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; tga = 2'b10;
    beat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (beat < 3) begin
        @(posedge clk); #1;
        if (ack[1]) begin
          chk($sformatf("burst%0d_edge", beat), 32'(n), 32'(2 * beat + 1));
          chk($sformatf("burst%0d_dat", beat), dat[1], 32'(beat + 1));
          chk($sformatf("burst%0d_tgd", beat), {30'h0, tgd[1]}, 32'h2);
          beat++;
          adr = 32'(beat * 4);
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("burst_beats", 32'(beat), 32'd3);
    @(posedge clk); #1;

    // Abort and reset-in-WAIT on instance 2 (WAIT_CYCLES=3)
    xfer(2, 1'b1, 32'h20, 4'hF, 32'h5A5A_0001, 2'd1, kind, lat, rd, rt);
    chk("w3_kind", 32'(kind), 32'd1);
    chk("w3_lat", 32'(lat), 32'd4);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; wdat = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    nack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[2]) nack++;
    end
    chk("abort_noack", 32'(nack), 32'd0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; wdat = 32'h0BAD_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rstwait_resp", {29'h0, ack[2], err[2], rty[2]}, 32'h0);
    chk("rstwait_dat", dat[2], 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, 2'd3, kind, lat, rd, rt);
    chk("abort_rd_kind", 32'(kind), 32'd1);
    chk("abort_rd_lat", 32'(lat), 32'd4);
    chk("abort_rd_dat", rd, 32'h5A5A_0001);
    chk("abort_rd_tgd", {30'h0, rt}, 32'h3);

`ifdef WB_RAM_RETRY_EN
    busy = 1'b1;
    xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 2'd1, kind, lat, rd, rt);
    chk("retry_kind", 32'(kind), 32'd3);
    chk("retry_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h2, 4'hF, 32'h0, 2'd1, kind, lat, rd, rt);
    chk("retry_err_prio", 32'(kind), 32'd2);
    busy = 1'b0;
    xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, 2'd1, kind, lat, rd, rt);
    chk("retry_again_kind", 32'(kind), 32'd1);
    chk("retry_again_dat", rd, 32'hCAFE_F00D);
`endif

    repeat (2) @(posedge clk);
    #2;
    chk("protocol_monitor", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
